// File: rtl/fix_msg_parse.sv
// FIX byte-stream receiver: reassembles tag=value<SOH> fields into parallel words
// and validates the trailing tag-10 checksum against a running mod-256 byte sum.
module fix_msg_parse #(
    parameter int VALUE_WIDTH = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             data_i,
    input  logic                   data_valid_i,
    output logic [31:0]            tag_o,
    output logic [4:0]             t_size_o,
    output logic [VALUE_WIDTH-1:0] val_o,
    output logic [7:0]             v_size_o,
    output logic                   field_valid_o,
    output logic                   end_o,
    output logic                   checksum_ok_o,
    output logic                   error_o
);

    localparam logic [7:0] SOH   = 8'h01;
    localparam logic [7:0] EQ    = 8'h3D;
    localparam logic [7:0] MAX_V = 8'(VALUE_WIDTH / 8);

    typedef enum logic [1:0] {
        S_TAG,
        S_VAL,
        S_ERR
    } state_t;

    state_t                 state_q, state_d;
    logic [31:0]            tag_q, tag_d;
    logic [2:0]             t_cnt_q, t_cnt_d;
    logic [VALUE_WIDTH-1:0] val_q, val_d;
    logic [7:0]             v_cnt_q, v_cnt_d;
    logic [7:0]             sum_q, sum_d;
    logic [7:0]             sum_pre_q, sum_pre_d;

    logic [31:0]            tag_nx;
    logic [4:0]             t_size_nx;
    logic [VALUE_WIDTH-1:0] val_nx;
    logic [7:0]             v_size_nx;
    logic                   fv_nx, end_nx, ok_nx, err_nx;
    logic                   clear_field;

    // The buffered tag still identifies the checksum field while its value or error tail streams in.
    logic       is_cks;
    logic [7:0] c0, c1, c2;
    logic       digits_ok;
    logic [9:0] cks_num;
    logic       cks_match;

    assign is_cks    = (t_cnt_q == 3'd2) && (tag_q == 32'h0000_3031);
    assign c0        = val_q[7:0];
    assign c1        = val_q[15:8];
    assign c2        = val_q[23:16];
    assign digits_ok = (c0 >= 8'h30) && (c0 <= 8'h39) &&
                       (c1 >= 8'h30) && (c1 <= 8'h39) &&
                       (c2 >= 8'h30) && (c2 <= 8'h39);
    assign cks_num   = 10'(c0 - 8'h30) * 10'd100 +
                       10'(c1 - 8'h30) * 10'd10 +
                       10'(c2 - 8'h30);
    assign cks_match = (v_cnt_q == 8'd3) && digits_ok && (cks_num == {2'b00, sum_pre_q});

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d     = state_q;
        tag_d       = tag_q;
        t_cnt_d     = t_cnt_q;
        val_d       = val_q;
        v_cnt_d     = v_cnt_q;
        sum_d       = sum_q;
        sum_pre_d   = sum_pre_q;
        tag_nx      = tag_o;
        t_size_nx   = t_size_o;
        val_nx      = val_o;
        v_size_nx   = v_size_o;
        fv_nx       = 1'b0;
        end_nx      = 1'b0;
        ok_nx       = 1'b0;
        err_nx      = 1'b0;
        clear_field = 1'b0;

        if (data_valid_i) begin
            sum_d = sum_q + data_i;
            case (state_q)
                S_TAG: begin
                    if (data_i == SOH) begin
                        err_nx      = 1'b1;
                        clear_field = 1'b1;
                    end else if (data_i == EQ) begin
                        if (t_cnt_q == 3'd0) begin
                            state_d = S_ERR;
                            err_nx  = 1'b1;
                        end else begin
                            state_d = S_VAL;
                        end
                    end else if (t_cnt_q == 3'd4) begin
                        state_d = S_ERR;
                        err_nx  = 1'b1;
                    end else begin
                        tag_d[t_cnt_q*8 +: 8] = data_i;
                        t_cnt_d               = t_cnt_q + 3'd1;
                        if (t_cnt_q == 3'd0) sum_pre_d = sum_q;
                    end
                end
                S_VAL: begin
                    if (data_i == SOH) begin
                        fv_nx       = 1'b1;
                        tag_nx      = tag_q;
                        t_size_nx   = {2'b00, t_cnt_q};
                        val_nx      = val_q;
                        v_size_nx   = v_cnt_q;
                        end_nx      = is_cks;
                        ok_nx       = is_cks && cks_match;
                        clear_field = 1'b1;
                    end else if (v_cnt_q == MAX_V) begin
                        state_d = S_ERR;
                        err_nx  = 1'b1;
                    end else begin
                        val_d[v_cnt_q*8 +: 8] = data_i;
                        v_cnt_d               = v_cnt_q + 8'd1;
                    end
                end
                S_ERR: begin
                    if (data_i == SOH) clear_field = 1'b1;
                end
                default: state_d = S_TAG;
            endcase

            if (clear_field) begin
                state_d = S_TAG;
                tag_d   = '0;
                t_cnt_d = '0;
                val_d   = '0;
                v_cnt_d = '0;
                if (is_cks) begin
                    sum_d     = '0;
                    sum_pre_d = '0;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; the field buffers are
    // ordinary flops and are cleared on reset together with everything else.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_TAG;
            tag_q         <= '0;
            t_cnt_q       <= '0;
            val_q         <= '0;
            v_cnt_q       <= '0;
            sum_q         <= '0;
            sum_pre_q     <= '0;
            tag_o         <= '0;
            t_size_o      <= '0;
            val_o         <= '0;
            v_size_o      <= '0;
            field_valid_o <= 1'b0;
            end_o         <= 1'b0;
            checksum_ok_o <= 1'b0;
            error_o       <= 1'b0;
        end else begin
            state_q       <= state_d;
            tag_q         <= tag_d;
            t_cnt_q       <= t_cnt_d;
            val_q         <= val_d;
            v_cnt_q       <= v_cnt_d;
            sum_q         <= sum_d;
            sum_pre_q     <= sum_pre_d;
            tag_o         <= tag_nx;
            t_size_o      <= t_size_nx;
            val_o         <= val_nx;
            v_size_o      <= v_size_nx;
            field_valid_o <= fv_nx;
            end_o         <= end_nx;
            checksum_ok_o <= ok_nx;
            error_o       <= err_nx;
        end
    end

endmodule

// File: tb/tb_fix_msg_parse.sv
// Bench for fix_msg_parse: directed scenarios plus random FIX messages, every cycle
// compared against a field-level reference model built from byte queues.
module tb_fix_msg_parse;

    localparam int VW = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    data_i;
    logic          data_valid_i;
    logic [31:0]   tag_o;
    logic [4:0]    t_size_o;
    logic [VW-1:0] val_o;
    logic [7:0]    v_size_o;
    logic          field_valid_o, end_o, checksum_ok_o, error_o;

    always #5 clk = ~clk;

    fix_msg_parse #(.VALUE_WIDTH(VW)) dut (
        .clk          (clk),
        .rst          (rst),
        .data_i       (data_i),
        .data_valid_i (data_valid_i),
        .tag_o        (tag_o),
        .t_size_o     (t_size_o),
        .val_o        (val_o),
        .v_size_o     (v_size_o),
        .field_valid_o(field_valid_o),
        .end_o        (end_o),
        .checksum_ok_o(checksum_ok_o),
        .error_o      (error_o)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: the bytes of the current field, then judged as a whole.
    logic [7:0]    fld[$];
    bit            bad;
    logic [7:0]    msum, fstart;
    logic [31:0]   e_tag;
    logic [4:0]    e_tsz;
    logic [VW-1:0] e_val;
    logic [7:0]    e_vsz;
    logic          e_fv, e_end, e_ok, e_err;

    int  seen_fv, seen_end, seen_err, seen_ok;
    int  gap_fixed;
    bit  gap_rand;

    task automatic check(input string name, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", name, obs, exp);
        end
    endtask

    task automatic check_outputs();
        check("field_valid", field_valid_o, e_fv);
        check("end", end_o, e_end);
        check("checksum_ok", checksum_ok_o, e_ok);
        check("error", error_o, e_err);
        check("tag", tag_o, e_tag);
        check("t_size", t_size_o, e_tsz);
        check("val", val_o, e_val);
        check("v_size", v_size_o, e_vsz);
    endtask

    task automatic model_reset();
        fld.delete();
        bad = 0; msum = 0; fstart = 0;
        e_tag = 0; e_tsz = 0; e_val = 0; e_vsz = 0;
        e_fv = 0; e_end = 0; e_ok = 0; e_err = 0;
    endtask

    function automatic int first_eq();
        for (int i = 0; i < fld.size(); i++)
            if (fld[i] == 8'h3D) return i;
        return -1;
    endfunction

    task automatic model_byte(input logic [7:0] b);
        int eq, tlen, num;
        bit is10, dig;
        e_fv = 0; e_end = 0; e_ok = 0; e_err = 0;
        if (fld.size() == 0) fstart = msum;
        msum = msum + b;
        if (b == 8'h01) begin
            eq   = first_eq();
            tlen = (eq < 0) ? fld.size() : eq;
            is10 = 0;
            if (tlen == 2) is10 = (fld[0] == 8'h31) && (fld[1] == 8'h30);
            if (!bad) begin
                if (eq < 0) begin
                    e_err = 1;
                end else begin
                    e_fv  = 1;
                    e_tag = 0;
                    for (int i = 0; i < tlen; i++) e_tag[i*8 +: 8] = fld[i];
                    e_tsz = 5'(tlen);
                    e_vsz = 8'(fld.size() - eq - 1);
                    e_val = 0;
                    for (int i = 0; i < int'(e_vsz); i++) e_val[i*8 +: 8] = fld[eq+1+i];
                    if (is10) begin
                        e_end = 1;
                        dig = (e_vsz == 3);
                        num = 0;
                        for (int i = 0; i < 3 && dig; i++) begin
                            if (fld[eq+1+i] < 8'h30 || fld[eq+1+i] > 8'h39) dig = 0;
                            else num = num * 10 + int'(fld[eq+1+i]) - 48;
                        end
                        e_ok = dig && (num == int'(fstart));
                    end
                end
            end
            if (is10) msum = 0;
            fld.delete();
            bad = 0;
        end else begin
            fld.push_back(b);
            if (!bad) begin
                eq = first_eq();
                if (eq == 0 || (eq < 0 && fld.size() > 4) || (eq > 0 && fld.size() - eq - 1 > VW / 8)) begin
                    bad   = 1;
                    e_err = 1;
                end
            end
        end
    endtask

    task automatic step(input logic v, input logic [7:0] b);
        data_valid_i = v;
        data_i       = v ? b : 8'($urandom_range(0, 255));
        @(posedge clk);
        #1;
        if (v) model_byte(b);
        else begin
            e_fv = 0; e_end = 0; e_ok = 0; e_err = 0;
        end
        if (field_valid_o) seen_fv++;
        if (error_o) seen_err++;
        if (end_o) begin
            seen_end++;
            seen_ok = checksum_ok_o;
        end
        check_outputs();
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        step(1'b1, b);
        n = gap_fixed;
        if (gap_rand) n = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
        repeat (n) step(1'b0, 8'h00);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic do_reset();
        data_valid_i = 1'b0;
        rst = 1'b0;
        #2;
        model_reset();
        check_outputs();
        @(posedge clk);
        #1;
        check_outputs();
        rst = 1'b1;
    endtask

    task automatic rand_field();
        int kind, n;
        kind = $urandom_range(0, 9);
        case (kind)
            0: begin
                repeat (5) send(8'($urandom_range(8'h30, 8'h39)));
                send_str("=X");
            end
            1: begin
                send(8'h3D);
                repeat ($urandom_range(0, 3)) send(8'($urandom_range(2, 255)));
            end
            2: send_str("12");
            3: begin
                send_str("58=");
                repeat ($urandom_range(VW / 8 + 1, VW / 8 + 4)) send(8'($urandom_range(2, 255)));
            end
            default: begin
                n = $urandom_range(1, 4);
                send(8'($urandom_range(8'h32, 8'h39)));
                repeat (n - 1) send(8'($urandom_range(8'h30, 8'h39)));
                send(8'h3D);
                repeat ($urandom_range(0, VW / 8)) send(8'($urandom_range(2, 255)));
            end
        endcase
        send(8'h01);
    endtask

    task automatic rand_msg();
        int cv, kind;
        repeat ($urandom_range(1, 4)) rand_field();
        kind = $urandom_range(0, 7);
        cv = int'(msum);
        if (kind == 0) begin
            send_str("10");
        end else if (kind == 1) begin
            send_str("10=");
            send(8'(48 + cv / 10 % 10));
            send(8'(48 + cv % 10));
        end else begin
            if (kind == 2) cv = (cv + $urandom_range(1, 50)) % 1000;
            send_str("10=");
            send(8'(48 + cv / 100));
            send(8'(48 + cv / 10 % 10));
            send(8'(48 + cv % 10));
        end
        send(8'h01);
    endtask

    initial begin
        int fv0, err0, end0;
        rst = 1'b0;
        data_valid_i = 1'b0;
        data_i = 8'h00;
        gap_fixed = 0;
        gap_rand = 0;
        seen_fv = 0; seen_end = 0; seen_err = 0; seen_ok = 0;
        model_reset();
        #3;
        check_outputs();
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Plain field 35=A.
        fv0 = seen_fv; err0 = seen_err; end0 = seen_end;
        send_str("35=A");
        send(8'h01);
        check("t1_fv_count", 32'(seen_fv - fv0), 1);
        check("t1_err_count", 32'(seen_err - err0), 0);
        check("t1_end_count", 32'(seen_end - end0), 0);
        check("t1_tag", tag_o, 32'h0000_3533);
        check("t1_tsize", t_size_o, 2);
        check("t1_val", val_o, 256'h41);
        check("t1_vsize", v_size_o, 1);

        // Good checksum, then a fresh message whose sum starts at zero.
        do_reset();
        send_str("8=F");
        send(8'h01);
        end0 = seen_end;
        send_str("10=188");
        send(8'h01);
        check("t2_end", 32'(seen_end - end0), 1);
        check("t2_ok", 32'(seen_ok), 1);
        check("t2_tag", tag_o, 32'h0000_3031);
        send_str("10=000");
        send(8'h01);
        check("t2_zero_sum_ok", 32'(seen_ok), 1);

        // Wrong checksum value and short checksum value.
        send_str("8=F");
        send(8'h01);
        send_str("10=187");
        send(8'h01);
        check("t3_wrong_ok", 32'(seen_ok), 0);
        send_str("8=F");
        send(8'h01);
        end0 = seen_end;
        send_str("10=18");
        send(8'h01);
        check("t3_short_end", 32'(seen_end - end0), 1);
        check("t3_short_ok", 32'(seen_ok), 0);
        check("t3_short_vsize", v_size_o, 2);

        // Over-long tag, then recovery.
        fv0 = seen_fv; err0 = seen_err;
        send_str("1234");
        send(8'h35);
        check("t4_err_pulse", error_o, 1);
        send_str("=Z");
        send(8'h01);
        check("t4_no_field", 32'(seen_fv - fv0), 0);
        send_str("35=A");
        send(8'h01);
        check("t4_err_count", 32'(seen_err - err0), 1);
        check("t4_fv_count", 32'(seen_fv - fv0), 1);
        check("t4_tag", tag_o, 32'h0000_3533);

        // Over-long value: 32 bytes fit, the 33rd errors.
        fv0 = seen_fv; err0 = seen_err;
        send_str("3=");
        repeat (VW / 8) send(8'h41);
        check("t5_no_err_at_max", 32'(seen_err - err0), 0);
        send(8'h41);
        check("t5_err_pulse", error_o, 1);
        send(8'h01);
        check("t5_no_field", 32'(seen_fv - fv0), 0);
        send_str("35=A");
        send(8'h01);
        check("t5_resync", 32'(seen_fv - fv0), 1);

        // Gapped stream, then reset in the middle of a field.
        gap_fixed = 3;
        fv0 = seen_fv;
        send_str("35=A");
        send(8'h01);
        check("t6_fv_count", 32'(seen_fv - fv0), 1);
        check("t6_tag", tag_o, 32'h0000_3533);
        check("t6_val", val_o, 256'h41);
        send_str("35=");
        do_reset();
        check("t6_rst_tag", tag_o, 0);
        check("t6_rst_vsize", v_size_o, 0);
        fv0 = seen_fv;
        repeat (5) step(1'b0, 8'h00);
        check("t6_quiet", 32'(seen_fv - fv0), 0);
        send_str("35=A");
        send(8'h01);
        check("t6_fresh", 32'(seen_fv - fv0), 1);
        gap_fixed = 0;

        // Random messages with mixed gaps and injected framing errors.
        gap_rand = 1;
        repeat (40) rand_msg();
        gap_rand = 0;
        repeat (3) step(1'b0, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fix_msg_parse.md
Name: fix_msg_parse

Overview:
Receive-side counterpart of the FIX message serializer. Consumes the serial FIX byte stream (tag, '=' 0x3D, value, SOH 0x01) one byte per valid cycle and reassembles each field into parallel tag/value words. Keeps a running mod-256 checksum and validates it against the trailing tag-10 field. Sits between the byte-stream ingress and the field/order-book logic.

Parameters:
VALUE_WIDTH, 256, value buffer width in bits; max value length is VALUE_WIDTH/8 bytes (32 by default).

Ports:
clk  in  1  clock; all state changes on rising edge.
rst  in  1  asynchronous, active-low reset.
data_i  in  8  stream byte.
data_valid_i  in  1  data_i is valid this cycle; no backpressure, so every valid byte is consumed.
tag_o  out  32  tag ASCII bytes; first byte at [7:0], unused bytes zero.
t_size_o  out  5  tag length in bytes (1..4).
val_o  out  VALUE_WIDTH  value ASCII bytes; first byte at [7:0], unused bytes zero.
v_size_o  out  8  value length in bytes (0..VALUE_WIDTH/8).
field_valid_o  out  1  one-cycle pulse: tag_o/val_o/sizes hold a new field.
end_o  out  1  one-cycle pulse: checksum field (tag "10") completed.
checksum_ok_o  out  1  valid with end_o: checksum matched.
error_o  out  1  one-cycle pulse: framing error detected.

Behaviour:
- Reset (rst=0, async): state=S_TAG; all outputs 0; byte counters, running sum and buffers cleared.
- States:
  - S_TAG: accumulate tag bytes.
  - S_VAL: accumulate value bytes.
  - S_ERR: discard bytes.
- Only cycles with data_valid_i=1 advance anything. Idle cycles hold all state.
- S_TAG:
  - Non-delimiter byte: store at tag buffer [cnt*8 +: 8], increment count.
  - 5th tag byte: go to S_ERR; error_o pulses the next cycle.
  - '=' with count>=1: go to S_VAL.
  - '=' with count=0, or SOH: go to S_ERR with error_o. A SOH here returns straight to S_TAG after the pulse.
- S_VAL:
  - Non-SOH byte: store at value buffer [cnt*8 +: 8]. '=' is legal data.
  - Byte number VALUE_WIDTH/8+1: go to S_ERR with error_o.
  - SOH: complete the field; the next cycle field_valid_o=1 with registered outputs; return to S_TAG with cleared counters/buffers.
- S_ERR: ignore bytes until SOH, then return to S_TAG. No field_valid_o is produced for the bad field.
- tag_o, val_o, t_size_o, v_size_o hold their last completed field until the next field_valid_o.
- Latency: field_valid_o is exactly 1 cycle after the terminating SOH is accepted.
- Checksum:
  - sum is an 8-bit wrapping adder over every accepted byte, delimiters included.
  - On the first tag byte of each field, latch sum_pre = sum before that byte.
- Checksum field: tag = "10" (t_size=2, tag[15:0]=0x3031).
  - On its SOH: field_valid_o and end_o both pulse.
  - checksum_ok_o=1 iff v_size=3, all three bytes are ASCII '0'..'9', and d0*100+d1*10+d2 (10-bit) == {2'b0, sum_pre}.
  - Then sum and sum_pre clear for the next message.
- Error inside a tag-10 field: error_o only; sum still clears on the SOH.
- A byte arriving the same cycle as a field_valid_o/end_o pulse is processed normally (back-to-back fields, zero gap).
- Reset mid-field: the partial field is discarded and no pulses are emitted.

Test Plan:
1. Bytes 33 35 3D 41 01, consecutive cycles -> 1 cycle after 01: field_valid_o=1, tag_o=0x00003533, t_size_o=2, val_o=0x41, v_size_o=1; end_o=0, error_o=0.
2. "8=F" SOH (sum 0xBC=188), then 31 30 3D 31 38 38 01 -> second field_valid_o with end_o=1, checksum_ok_o=1; following message sum starts at 0.
3. Same as 2, but value "187" -> end_o=1, checksum_ok_o=0. Value "18" (v_size 2) -> checksum_ok_o=0.
4. 31 32 33 34 35 3D 5A 01 then 33 35 3D 41 01 -> error_o one pulse after 0x35, no field_valid_o for the bad field, then a correct field for 35=A.
5. 33 3D followed by 33 bytes of 0x41 -> error_o on the 33rd value byte; resync on the next SOH.
6. Test 1 with data_valid_i low for 3 cycles between every byte, plus rst pulsed low after "35=" -> identical output to test 1 when gaps are used; after reset, all outputs 0 and no field_valid_o until a fresh field is sent.
